// File: rtl/ob_pkg.sv
// Shared order-book types: table entry layout, price sentinels, controller opcodes and statuses.
package ob_pkg;

  typedef logic [15:0] uid_t;
  typedef logic [15:0] price_t;
  typedef logic [15:0] qty_t;

  typedef struct packed {
    uid_t   uid;
    price_t price;
    qty_t   qty;
  } table_t;

  localparam price_t PRICE_MAX = '1;
  localparam price_t PRICE_MIN = '0;

  typedef enum logic [1:0] {
    OP_NOP      = 2'd0,
    OP_INSERT   = 2'd1,
    OP_CANCEL   = 2'd2,
    OP_POP_HEAD = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK          = 2'd0,
    ST_CANCEL_MISS = 2'd1,
    ST_REJECT      = 2'd2,
    ST_EMPTY       = 2'd3
  } status_e;

endpackage

// File: rtl/ob_table_ctrl_if.sv
// Command/response port of the table controller: valid/ready command in, valid/ready response out.
interface ob_table_ctrl_if;
  import ob_pkg::*;

  logic    cmd_vld;
  logic    cmd_rdy;
  op_e     cmd_op;
  table_t  cmd_tbl;
  logic    rsp_vld;
  logic    rsp_rdy;
  status_e rsp_status;
  table_t  rsp_tbl;

  // Front end side
  modport master (
    output cmd_vld, cmd_op, cmd_tbl, rsp_rdy,
    input  cmd_rdy, rsp_vld, rsp_status, rsp_tbl
  );

  // Controller side
  modport slave (
    input  cmd_vld, cmd_op, cmd_tbl, rsp_rdy,
    output cmd_rdy, rsp_vld, rsp_status, rsp_tbl
  );
endinterface

// File: rtl/ob_table_ctrl.sv
// Sequences insert / cancel / pop-head commands into one ob_table, collects the
// table's answer, drains its reject slot after inserts and returns one response
// per command plus one REJECT response per evicted entry.
module ob_table_ctrl
  import ob_pkg::*;
#(
  parameter bit is_ask = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  ob_table_ctrl_if.slave    cmd,
  output logic              tbl_insert,
  output table_t            tbl_insert_tbl,
  output logic              tbl_cancel,
  output uid_t              tbl_cancel_uid,
  input  logic              tbl_cancel_hit_w,
  input  table_t            tbl_cancel_hit_tbl_w,
  output logic              tbl_head_pop,
  input  logic              tbl_head_vld_r,
  input  table_t            tbl_head_r,
  output logic              tbl_reject_pop,
  input  logic              tbl_reject_vld_r,
  input  table_t            tbl_reject_r,
  output logic [CNT_W-1:0]  rej_cnt_r
);

  // Sentinel price the table uses for empty slots; a real order must never carry it.
  localparam price_t INVALID_PRICE = is_ask ? PRICE_MAX : PRICE_MIN;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_RSP,
    S_RSP_EVICT
  } state_e;

  state_e           state;
  op_e              op_r;
  table_t           cmd_r;
  table_t           evict_r;
  logic             evict_pend_r;
  logic             cmd_rdy_r;
  logic             rsp_vld_r;
  status_e          rsp_status_r;
  table_t           rsp_tbl_r;
  logic [CNT_W-1:0] rej_cnt_q;

  assign cmd.cmd_rdy    = cmd_rdy_r;
  assign cmd.rsp_vld    = rsp_vld_r;
  assign cmd.rsp_status = rsp_status_r;
  assign cmd.rsp_tbl    = rsp_tbl_r;
  assign rej_cnt_r      = rej_cnt_q;

  // Strobes are pure decodes of registered state, so they can only be high in
  // ISSUE or SETTLE and at most one op decode is true at a time.
  assign tbl_insert     = (state == S_ISSUE)  && (op_r == OP_INSERT);
  assign tbl_cancel     = (state == S_ISSUE)  && (op_r == OP_CANCEL);
  assign tbl_head_pop   = (state == S_ISSUE)  && (op_r == OP_POP_HEAD) && tbl_head_vld_r;
  assign tbl_reject_pop = (state == S_SETTLE) && (op_r == OP_INSERT)   && tbl_reject_vld_r;
  assign tbl_insert_tbl = cmd_r;
  assign tbl_cancel_uid = cmd_r.uid;

  // Command sequencer FSM with registered response outputs and reject counter.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: every register here is a plain flop (no memory array), so all get a reset value.
      state        <= S_IDLE;
      op_r         <= OP_NOP;
      cmd_r        <= '0;
      evict_r      <= '0;
      evict_pend_r <= 1'b0;
      cmd_rdy_r    <= 1'b0;
      rsp_vld_r    <= 1'b0;
      rsp_status_r <= ST_OK;
      rsp_tbl_r    <= '0;
      rej_cnt_q    <= '0;
    end else begin
      if (rsp_vld_r && cmd.rsp_rdy && (rsp_status_r == ST_REJECT) && (rej_cnt_q != '1)) begin
        rej_cnt_q <= rej_cnt_q + 1'b1;
      end

      case (state)
        S_IDLE: begin
          cmd_rdy_r <= 1'b1;
          if (cmd.cmd_vld && cmd_rdy_r && (cmd.cmd_op != OP_NOP)) begin
            op_r         <= cmd.cmd_op;
            cmd_r        <= cmd.cmd_tbl;
            evict_pend_r <= 1'b0;
            cmd_rdy_r    <= 1'b0;
            state        <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          case (op_r)
            OP_CANCEL: begin
              rsp_status_r <= tbl_cancel_hit_w ? ST_OK : ST_CANCEL_MISS;
              rsp_tbl_r    <= tbl_cancel_hit_w ? tbl_cancel_hit_tbl_w : cmd_r;
            end
            OP_POP_HEAD: begin
              rsp_status_r <= tbl_head_vld_r ? ST_OK : ST_EMPTY;
              rsp_tbl_r    <= tbl_head_vld_r ? tbl_head_r : '0;
            end
            default: begin
              rsp_status_r <= ST_OK;
              rsp_tbl_r    <= cmd_r;
            end
          endcase
          state <= S_SETTLE;
        end

        S_SETTLE: begin
          // The reject slot now reflects the insert; if it holds our own entry the
          // insert itself lost, otherwise an older entry was pushed out.
          if ((op_r == OP_INSERT) && tbl_reject_vld_r) begin
            evict_r <= tbl_reject_r;
            if (tbl_reject_r.uid == cmd_r.uid) begin
              rsp_status_r <= ST_REJECT;
            end else begin
              evict_pend_r <= 1'b1;
            end
          end
          rsp_vld_r <= 1'b1;
          state     <= S_RSP;
        end

        S_RSP: begin
          if (cmd.rsp_rdy) begin
            if (evict_pend_r) begin
              rsp_status_r <= ST_REJECT;
              rsp_tbl_r    <= evict_r;
              evict_pend_r <= 1'b0;
              state        <= S_RSP_EVICT;
            end else begin
              rsp_vld_r <= 1'b0;
              cmd_rdy_r <= 1'b1;
              state     <= S_IDLE;
            end
          end
        end

        S_RSP_EVICT: begin
          if (cmd.rsp_rdy) begin
            rsp_vld_r <= 1'b0;
            cmd_rdy_r <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Sanity checks on the table-side strobes.
  a_strobe_onehot: assert property (@(posedge clk) disable iff (!rst)
    $countones({tbl_insert, tbl_cancel, tbl_head_pop, tbl_reject_pop}) <= 1);
  a_insert_price: assert property (@(posedge clk) disable iff (!rst)
    tbl_insert |-> (tbl_insert_tbl.price != INVALID_PRICE));

endmodule

// File: doc/ob_table_ctrl.md
Name: ob_table_ctrl

Overview:
- Command sequencer that drives one ob_table instance (bid or ask) from the initiator side.
- Accepts insert, cancel and pop-head commands on a valid/ready port and issues single-cycle strobes to the table.
- Collects cancel-hit results, drains the table reject slot, and returns one response per command, plus one extra response per evicted entry.
- Sits between the order-entry front end and the table.

Parameters:
- is_ask, 1, side of the controlled table; selects INVALID_PRICE (PRICE_MAX for ask, PRICE_MIN for bid).
- CNT_W, 16, width of the saturating reject counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command ready
- cmd_op  in  2  command opcode: 0 NOP, 1 INSERT, 2 CANCEL, 3 POP_HEAD
- cmd_tbl  in  ob_pkg::table_t  entry for INSERT; uid field used for CANCEL
- rsp_vld  out  1  response valid
- rsp_rdy  in  1  response ready
- rsp_status  out  2  response status: 0 OK, 1 CANCEL_MISS, 2 REJECT, 3 EMPTY
- rsp_tbl  out  ob_pkg::table_t  entry associated with the response
- tbl_insert  out  1  insert strobe to the table
- tbl_insert_tbl  out  ob_pkg::table_t  insert payload
- tbl_cancel  out  1  cancel strobe to the table
- tbl_cancel_uid  out  ob_pkg::uid_t  uid to cancel
- tbl_cancel_hit_w  in  1  combinational cancel hit from the table
- tbl_cancel_hit_tbl_w  in  ob_pkg::table_t  entry that was hit
- tbl_head_pop  out  1  head pop strobe to the table
- tbl_head_vld_r  in  1  table head valid
- tbl_head_r  in  ob_pkg::table_t  table head entry
- tbl_reject_pop  out  1  reject pop strobe to the table
- tbl_reject_vld_r  in  1  table reject slot valid
- tbl_reject_r  in  ob_pkg::table_t  table reject entry
- rej_cnt_r  out  CNT_W  number of REJECT responses issued, saturating

Behaviour:
- Reset (rst=0, async): state IDLE; all strobes 0; rsp_vld 0; rsp_tbl 0; rsp_status 0; rej_cnt_r 0; cmd register 0.
- Reset asserted mid-operation abandons the command. No response is issued and no strobe is emitted after reset release until a new command is accepted.
- States: IDLE, ISSUE, SETTLE, RSP, RSP_EVICT.
- IDLE:
  - cmd_rdy = 1 and no response is pending.
  - On handshake with cmd_op != NOP, register op and cmd_tbl, then go to ISSUE.
  - NOP is accepted and dropped, with no response.
- ISSUE (exactly one cycle), exactly one strobe is high:
  - INSERT: tbl_insert=1, payload = registered cmd_tbl.
  - CANCEL: tbl_cancel=1. Capture tbl_cancel_hit_w and tbl_cancel_hit_tbl_w this cycle. Status is OK with the hit entry, or CANCEL_MISS with rsp_tbl = cmd_tbl.
  - POP_HEAD: if tbl_head_vld_r, pulse tbl_head_pop and capture tbl_head_r, status OK. Otherwise no strobe, status EMPTY, rsp_tbl = 0.
  - Then go to SETTLE.
- SETTLE (one cycle; table state from the ISSUE cycle is now visible):
  - If op=INSERT and tbl_reject_vld_r:
    - Pulse tbl_reject_pop and latch tbl_reject_r as evict_r.
    - If tbl_reject_r.uid == cmd uid, the response status becomes REJECT and no eviction is pending.
    - Otherwise the status is OK and an eviction is pending.
  - All other ops: no reject_pop.
  - Go to RSP.
- RSP: rsp_vld=1, payload held stable until rsp_rdy.
  - On handshake, go to RSP_EVICT if an eviction is pending, else IDLE.
- RSP_EVICT: rsp_vld=1, status REJECT, rsp_tbl = evict_r. On handshake go to IDLE.
- Latency (command accepted in cycle T):
  - Strobe in T+1.
  - reject_pop in T+2.
  - rsp_vld first high in T+3 for every non-NOP op.
  - Minimum command-to-command spacing is 4 cycles; each rsp_rdy stall cycle adds one.
- Backpressure: rsp_vld must not drop and the payload must not change until the handshake.
- rej_cnt_r increments by 1 on each REJECT response handshake and saturates at all-ones.
- Invariants:
  - At most one of tbl_insert / tbl_cancel / tbl_head_pop / tbl_reject_pop is high in any cycle.
  - No strobe outside ISSUE or SETTLE.
- tbl_reject_vld_r high while in IDLE (a stale reject) is not popped there. It is drained in SETTLE of the next INSERT.

Test Plan:
- Ask table, empty. INSERT uid=5 price=100 at T -> tbl_insert pulse at T+1; at T+3 rsp_vld with status OK, rsp_tbl.uid=5; no reject_pop.
- Ask table, full (N=16) with prices 1..16. INSERT uid=99 price=200 -> reject_pop at T+2; single response REJECT uid=99; rej_cnt_r=1.
- Ask table, full with prices 1..16. INSERT uid=50 price=0 -> response OK uid=50, then RSP_EVICT response REJECT with the price-16 entry; rej_cnt_r=1.
- Cancel: uid=5 present -> OK with its entry. Cancel uid=7 absent -> CANCEL_MISS, rsp_tbl.uid=7.
- POP_HEAD on an empty table -> EMPTY, no tbl_head_pop. POP_HEAD on a non-empty table -> tbl_head_pop pulse and OK with the head entry.
- Hold rsp_rdy=0 for 10 cycles -> rsp_vld stays high with a stable payload and cmd_rdy=0. Assert rst=0 mid-stall -> all outputs return to 0 asynchronously, and the response is not reissued after release.
